// File: rtl/gat_bram_load_bridge_if.sv
// rtl/gat_bram_load_bridge_if.sv - host/core bus bundle for the GAT BRAM load bridge
interface gat_bram_load_bridge_if #(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 27,
    parameter int ADDR_W    = 18,
    parameter int RD_ADDR_W = 16
);
    localparam int BEATS  = (DATA_W + TOP_WIDTH - 1) / TOP_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int HA_W   = ADDR_W + BEAT_W + 2;
    localparam int CNT_W  = ADDR_W + 1;

    logic                        start;
    logic [NUM_CH*CNT_W-1:0]     expected_words;
    logic [NUM_CH-1:0]           host_ena;
    logic [NUM_CH-1:0]           host_wea;
    logic [NUM_CH*HA_W-1:0]      host_addr;
    logic [NUM_CH*TOP_WIDTH-1:0] host_din;
    logic [NUM_CH-1:0]           bram_we;
    logic [NUM_CH*ADDR_W-1:0]    bram_addr;
    logic [NUM_CH*DATA_W-1:0]    bram_din;
    logic [NUM_CH-1:0]           load_done;
    logic                        core_start;
    logic                        core_done;
    logic                        ready;
    logic                        err_overflow;
    logic                        err_proto;
    logic [RD_ADDR_W+1:0]        rd_addr;
    logic [RD_ADDR_W-1:0]        core_rd_addr;
    logic [TOP_WIDTH-1:0]        core_rd_data;
    logic [TOP_WIDTH-1:0]        rd_dout;

    modport slave (
        input  start, expected_words, host_ena, host_wea, host_addr, host_din,
               core_done, rd_addr, core_rd_data,
        output bram_we, bram_addr, bram_din, load_done, core_start, ready,
               err_overflow, err_proto, core_rd_addr, rd_dout
    );

    modport master (
        output start, expected_words, host_ena, host_wea, host_addr, host_din,
               core_done, rd_addr, core_rd_data,
        input  bram_we, bram_addr, bram_din, load_done, core_start, ready,
               err_overflow, err_proto, core_rd_addr, rd_dout
    );
endinterface

// File: rtl/gat_bram_load_bridge.sv
// rtl/gat_bram_load_bridge.sv - host-to-core BRAM load bridge with word packing and layer sequencing
module gat_bram_load_bridge #(
    parameter int TOP_WIDTH = 32,
    parameter int NUM_CH    = 3,
    parameter int DATA_W    = 27,
    parameter int ADDR_W    = 18,
    parameter int RD_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    gat_bram_load_bridge_if.slave bus
);
    localparam int BEATS  = (DATA_W + TOP_WIDTH - 1) / TOP_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int HA_W   = ADDR_W + BEAT_W + 2;
    localparam int CNT_W  = ADDR_W + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ARM, ST_BUSY, ST_DONE} state_t;

    state_t state_q;
    logic   core_start_q, ready_q;

    logic [NUM_CH-1:0]                      wr, last;
    logic [NUM_CH-1:0][BEAT_W-1:0]          beat;
    logic [NUM_CH-1:0][ADDR_W-1:0]          word;
    logic [NUM_CH-1:0][CNT_W-1:0]           expected_q, expected_d, count_q, count_d;
    logic [NUM_CH-1:0][BEATS*TOP_WIDTH-1:0] asm_q, asm_d, merged;
    logic [NUM_CH-1:0]                      bram_we_q, bram_we_d, load_done_q, load_done_d;
    logic [NUM_CH-1:0][ADDR_W-1:0]          bram_addr_q, bram_addr_d;
    logic [NUM_CH-1:0][DATA_W-1:0]          bram_din_q, bram_din_d;
    logic                                   err_ov_q, err_ov_d, err_pr_q, err_pr_d;
    logic [TOP_WIDTH-1:0]                   rd_dout_q;
    logic                                   start_ok, in_load, unused_sink;

    assign start_ok = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign in_load  = (state_q == ST_LOAD);

    // Decode each channel's host strobe into beat index, word address and last-beat flag
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr[c]   = bus.host_ena[c] & bus.host_wea[c];
            beat[c] = (BEATS == 1) ? '0 : bus.host_addr[c*HA_W+2 +: BEAT_W];
            word[c] = bus.host_addr[c*HA_W+BEAT_W+2 +: ADDR_W];
            last[c] = (int'(beat[c]) == BEATS - 1);
        end
    end

    // Byte-lane bits, the beat field when BEATS=1 and assembly bits above DATA_W are don't-cares
    always_comb unused_sink = ^{bus.host_addr, bus.rd_addr[1:0], merged};

    // Beat assembly, word completion, per-channel counting and sticky error flags
    always_comb begin
        expected_d  = expected_q;
        count_d     = count_q;
        asm_d       = asm_q;
        load_done_d = load_done_q;
        bram_we_d   = '0;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        err_ov_d    = err_ov_q;
        err_pr_d    = err_pr_q;
        merged      = asm_q;
        if (start_ok) begin
            err_ov_d = 1'b0;
            err_pr_d = 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                expected_d[c]  = bus.expected_words[c*CNT_W +: CNT_W];
                count_d[c]     = '0;
                load_done_d[c] = (expected_d[c] == '0);
            end
        end
        for (int c = 0; c < NUM_CH; c++) begin
            merged[c][int'(beat[c])*TOP_WIDTH +: TOP_WIDTH] = bus.host_din[c*TOP_WIDTH +: TOP_WIDTH];
            if (wr[c]) begin
                if (!in_load) begin
                    err_pr_d = 1'b1;
                end else if (last[c]) begin
                    if (count_q[c] == expected_q[c]) begin
                        err_ov_d = 1'b1;
                    end else begin
                        bram_we_d[c]   = 1'b1;
                        bram_addr_d[c] = word[c];
                        bram_din_d[c]  = merged[c][DATA_W-1:0];
                        count_d[c]     = count_q[c] + CNT_W'(1);
                        if (count_d[c] == expected_q[c]) load_done_d[c] = 1'b1;
                    end
                end else if (int'(beat[c]) < BEATS - 1) begin
                    asm_d[c] = merged[c];
                end
            end
        end
    end

    // Datapath registers and the readback output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected_q  <= '0;
            count_q     <= '0;
            asm_q       <= '0;
            load_done_q <= '0;
            bram_we_q   <= '0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            err_ov_q    <= 1'b0;
            err_pr_q    <= 1'b0;
            rd_dout_q   <= '0;
        end else begin
            expected_q  <= expected_d;
            count_q     <= count_d;
            asm_q       <= asm_d;
            load_done_q <= load_done_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            err_ov_q    <= err_ov_d;
            err_pr_q    <= err_pr_d;
            rd_dout_q   <= bus.core_rd_data;
        end
    end

    // Layer sequencer: load, arm the core with a one-cycle start, wait for done, expose results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            core_start_q <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            core_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: if (bus.start) state_q <= ST_LOAD;
                ST_LOAD: if (&load_done_q) state_q <= ST_ARM;
                ST_ARM: begin
                    state_q      <= ST_BUSY;
                    core_start_q <= 1'b1;
                end
                ST_BUSY: if (bus.core_done) begin
                    state_q <= ST_DONE;
                    ready_q <= 1'b1;
                end
                ST_DONE: if (bus.start) begin
                    state_q <= ST_LOAD;
                    ready_q <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bram_we      = bram_we_q;
    assign bus.bram_addr    = bram_addr_q;
    assign bus.bram_din     = bram_din_q;
    assign bus.load_done    = load_done_q;
    assign bus.core_start   = core_start_q;
    assign bus.ready        = ready_q;
    assign bus.err_overflow = err_ov_q;
    assign bus.err_proto    = err_pr_q;
    assign bus.core_rd_addr = bus.rd_addr[RD_ADDR_W+1:2];
    assign bus.rd_dout      = rd_dout_q;
endmodule
